// File: rtl/stack_pkg.sv
// Shared definitions for the stack sequencer: opcodes, stack move codes and
// the per-opcode minimum-depth / net-depth tables.
package stack_pkg;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_PUSH = 4'd1;
  localparam logic [3:0] OP_POP  = 4'd2;
  localparam logic [3:0] OP_REPL = 4'd3;
  localparam logic [3:0] OP_DUP  = 4'd4;
  localparam logic [3:0] OP_SWAP = 4'd5;
  localparam logic [3:0] OP_OVER = 4'd6;
  localparam logic [3:0] OP_NIP  = 4'd7;
  localparam logic [3:0] OP_CLRF = 4'd8;

  localparam logic [1:0] DELTA_HOLD = 2'b00;
  localparam logic [1:0] DELTA_PUSH = 2'b01;
  localparam logic [1:0] DELTA_POP  = 2'b11;

  function automatic logic [1:0] op_min_depth(input logic [3:0] op);
    case (op)
      OP_POP, OP_REPL, OP_DUP:  return 2'd1;
      OP_SWAP, OP_OVER, OP_NIP: return 2'd2;
      default:                  return 2'd0;
    endcase
  endfunction

  function automatic logic signed [1:0] op_net_delta(input logic [3:0] op);
    case (op)
      OP_PUSH, OP_DUP, OP_OVER: return 2'sd1;
      OP_POP, OP_NIP:           return -2'sd1;
      default:                  return 2'sd0;
    endcase
  endfunction

endpackage

// File: rtl/stack_seq_if.sv
// Operation request channel from core decode into the stack sequencer.
interface stack_seq_if #(
  parameter int WIDTH = 16
) ();
  logic             op_valid;
  logic [3:0]       op_code;
  logic [WIDTH-1:0] op_data;
  logic             op_ready;

  modport master (output op_valid, op_code, op_data, input  op_ready);
  modport slave  (input  op_valid, op_code, op_data, output op_ready);
endinterface

// File: rtl/stack_depth_ctr.sv
// Saturating live-entry counter for the stack with sticky overflow/underflow
// flags; updated once per accepted operation.
module stack_depth_ctr #(
  parameter  int DEPTH = 18,
  localparam int DW    = $clog2(DEPTH + 2)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_acc,
  input  logic [1:0]        i_min,
  input  logic signed [1:0] i_net,
  input  logic              i_clr,
  output logic [DW-1:0]     o_depth,
  output logic              o_overflow,
  output logic              o_underflow
);
  localparam int CAP = DEPTH + 1;

  logic [DW-1:0]        r_depth;
  logic                 r_overflow;
  logic                 r_underflow;
  logic signed [DW+1:0] w_sum;
  logic                 w_over;
  logic                 w_short;
  logic [DW-1:0]        w_depth_nxt;

  // Two guard bits keep depth+net representable as a signed value.
  assign w_sum   = $signed({2'b00, r_depth}) + $signed({{DW{i_net[1]}}, i_net});
  assign w_over  = int'(w_sum) > CAP;
  assign w_short = r_depth < {{(DW-2){1'b0}}, i_min};

  always_comb begin
    w_depth_nxt = w_sum[DW-1:0];
    if (w_sum[DW+1])
      w_depth_nxt = '0;
    else if (w_over)
      w_depth_nxt = DW'(CAP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_depth     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (i_acc)
        r_depth <= w_depth_nxt;
      if (i_clr) begin
        r_overflow  <= 1'b0;
        r_underflow <= 1'b0;
      end else if (i_acc) begin
        r_overflow  <= r_overflow  | w_over;
        r_underflow <= r_underflow | w_short;
      end
    end
  end

  assign o_depth     = r_depth;
  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;
endmodule

// File: rtl/stack_seq.sv
// Stack sequencer: breaks decode-level stack operations into single-cycle
// we/delta/wd primitives for one hardware stack, tracking depth and errors.
module stack_seq
  import stack_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 18
) (
  input  logic                         clk,
  input  logic                         rst,
  stack_seq_if.slave                   op,
  output logic [WIDTH-1:0]             tos,
  output logic [$clog2(DEPTH+2)-1:0]   depth,
  output logic                         overflow,
  output logic                         underflow,
  output logic                         st_we,
  output logic [1:0]                   st_delta,
  output logic [WIDTH-1:0]             st_wd,
  input  logic [WIDTH-1:0]             st_rd
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_S1   = 2'd1;
  localparam logic [1:0] ST_S2   = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_t;
  logic [WIDTH-1:0] r_n;
  logic             w_acc;
  logic             w_we;
  logic [1:0]       w_delta;
  logic [WIDTH-1:0] w_wd;

  assign op.op_ready = (r_state == ST_IDLE) & ~rst;
  assign w_acc       = op.op_valid & op.op_ready;

  // First primitive is issued in the accept cycle; S1/S2 finish SWAP/OVER/NIP.
  always_comb begin
    w_we        = 1'b0;
    w_delta     = DELTA_HOLD;
    w_wd        = '0;
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_acc) begin
          case (op.op_code)
            OP_PUSH: begin w_we = 1'b1; w_delta = DELTA_PUSH; w_wd = op.op_data; end
            OP_POP:  w_delta = DELTA_POP;
            OP_REPL: begin w_we = 1'b1; w_delta = DELTA_HOLD; w_wd = op.op_data; end
            OP_DUP:  begin w_we = 1'b1; w_delta = DELTA_PUSH; w_wd = st_rd;      end
            OP_SWAP, OP_OVER, OP_NIP: begin
              w_delta     = DELTA_POP;
              w_state_nxt = ST_S1;
            end
            default: ;
          endcase
        end
      end
      ST_S1: begin
        w_we = 1'b1;
        w_wd = r_t;
        case (r_op)
          OP_SWAP: begin w_delta = DELTA_HOLD; w_state_nxt = ST_S2;   end
          OP_OVER: begin w_delta = DELTA_PUSH; w_state_nxt = ST_S2;   end
          default: begin w_delta = DELTA_HOLD; w_state_nxt = ST_IDLE; end
        endcase
      end
      ST_S2: begin
        w_we        = 1'b1;
        w_delta     = DELTA_PUSH;
        w_wd        = r_n;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (rst) begin
      w_we    = 1'b0;
      w_delta = DELTA_HOLD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_op    <= OP_NOP;
    end else begin
      r_state <= w_state_nxt;
      if (w_acc)
        r_op <= op.op_code;
    end
  end

  // Holding registers carry stack data only, so they are left unreset.
  always_ff @(posedge clk) begin
    if (w_acc)
      r_t <= st_rd;
    if (r_state == ST_S1)
      r_n <= st_rd;
  end

  stack_depth_ctr #(.DEPTH(DEPTH)) u_depth (
    .clk         (clk),
    .rst         (rst),
    .i_acc       (w_acc),
    .i_min       (op_min_depth(op.op_code)),
    .i_net       (op_net_delta(op.op_code)),
    .i_clr       (w_acc & (op.op_code == OP_CLRF)),
    .o_depth     (depth),
    .o_overflow  (overflow),
    .o_underflow (underflow)
  );

  assign tos      = st_rd;
  assign st_we    = w_we;
  assign st_delta = w_delta;
  assign st_wd    = w_wd;
endmodule
